chunk_loader: RTL and testbench
===============================

# chunk_loader

Upstream feeder for the chunk hasher. Accepts one message of up to 1024 bytes as a 32-bit valid/ready stream and packs it into a 16-block × 64-byte register buffer. It then issues a one-cycle update pulse with the byte count, and serves the hasher's block-address reads with zero-padded 512-bit blocks. It holds off the next message until the hasher signals completion.

## Interface
- No parameters. Buffer depth is fixed at 16 blocks (1024 bytes, the chunk size).
- Clk  in  1  clock.
- Rst_n  in  1  reset. Asynchronous, active-low.
- S_valid_I  in  1  input word valid.
- S_ready_O  out  1  input word accepted when S_valid_I && S_ready_O.
- S_data_I  in  32  message word, little-endian (byte 0 = bits [7:0]).
- S_keep_I  in  4  valid bytes on the last word (thermometer from bit 0); ignored on non-last words.
- S_last_I  in  1  final word of the message.
- Addr_I  in  10  block index from the hasher.
- Msg_O  out  16×32  block at Addr_I, masked.
- Byte_num_O  out  11  byte count of the issued message (0..1024).
- Update_O  out  1  one-cycle pulse that starts the hasher.
- Done_I  in  1  hasher result-valid level.
- Busy_O  out  1  message issued, hash not yet complete.
- Err_O  out  1  overflow flag for the current/last message.

## Operation
- The FSM has three states: FILL, ISSUE and WAIT. The reset state is FILL.
- **FILL**
  - S_ready_O=1.
  - Each accepted word k (word_cnt, 9 bits) is written to buf[k[7:4]][k[3:0]] while k<256.
  - Non-last words add 4 to byte_cnt.
  - The last word adds its keep count, which is the number of consecutive 1s from bit 0 (4'h0→0, 1→1, 3→2, 7→3, F→4; other values count only leading ones). Bytes beyond the count are stored as 0.
  - Words accepted at k≥256 are discarded and set Err_O. byte_cnt saturates at 1024.
  - Accepting the first word of a message clears Err_O, word_cnt and byte_cnt before counting that word.
  - Accepting a word with S_last_I=1 moves the FSM to ISSUE.
- **ISSUE** (exactly one cycle)
  - Update_O=1 and Byte_num_O←final byte_cnt (registered, valid the same cycle as Update_O).
  - S_ready_O=0, Busy_O=1. The FSM then moves to WAIT.
- **WAIT**
  - S_ready_O=0, Busy_O=1.
  - The block samples Done_I into done_q.
  - It leaves WAIT only on a rising edge, defined as Done_I=1 && done_q=0, observed while in WAIT. A stale Done_I level left high from the previous message is ignored.
  - On the rising edge the FSM returns to FILL.
- **Read path** (combinational from buffer registers)
  - If Addr_I[9:4]≠0, Msg_O=0.
  - Otherwise Msg_O[i] = buf[Addr_I[3:0]][i], with every byte whose offset Addr_I*64 + 4i + b ≥ Byte_num_O forced to 0. This gives zero padding of partial or unwritten blocks without clearing the buffer.
- An empty message (first word has S_last_I=1 and keep=0) issues Byte_num_O=0.
- Buffer contents are overwritten only in FILL, so the hasher reads stable data throughout WAIT.

## Timing
- **Reset values:**
  - State FILL, S_ready_O=1.
  - Update_O=0, Byte_num_O=0, Busy_O=0, Err_O=0.
  - Buffer all 0, word_cnt=0, byte_cnt=0, done_q=0.
  - Msg_O=0.
- **Issue latency:** last word accepted at cycle t gives Update_O=1 at t+1 and WAIT at t+2.
- **Completion latency:** Done_I rising edge at cycle d gives FILL at d+1, so S_ready_O=1 at d+1.
- Read latency on Msg_O is 0 cycles after Addr_I.
- **Reset mid-operation:** Rst_n low in any state immediately forces the reset values. The next accepted word is word 0 of a new message.
- Update_O is never high for two consecutive cycles.

## Test plan
- **Full block:** 16 words 0x03020100..0x3F3E3D3C, last with keep=F.
  - Update_O pulses exactly one cycle after the last handshake, with Byte_num_O=64.
  - Addr_I=0 returns the words in order.
  - Addr_I=1 returns all zeros.
- **Partial and empty message:**
  - Word 0xAABBCCDD, then 0x11223344 with last and keep=1: Byte_num_O=5 and Msg_O[1]=0x00000044.
  - A following message of one word with last and keep=0: Byte_num_O=0 and Msg_O=0.
- **Full chunk:** 256 words, last keep=F.
  - Byte_num_O=1024 and Err_O=0.
  - Addr_I=15 returns words 240..255.
  - Addr_I=16 returns 0.
- **Overflow:** 260 words.
  - Err_O=1 and Byte_num_O=1024.
  - Block 15 holds words 240..255; words 256..259 are absent.
  - Err_O clears on the first word of the next message.
- **Done handshake:**
  - Done_I held 1 through ISSUE and into WAIT: S_ready_O stays 0.
  - Done_I falls, then rises at cycle d: S_ready_O=1 at d+1.
- **Reset mid-FILL:** Rst_n pulsed after 10 words.
  - All outputs return to reset values.
  - A subsequent 3-word message (last keep=F) issues Byte_num_O=12.

Source files
------------

// File: rtl/chunk_loader.sv
// chunk_loader
// Upstream feeder for the chunk hasher. Packs one message (up to 1024 bytes)
// from a 32-bit valid/ready stream into a 16-block x 64-byte register buffer.
// It then pulses Update_O with the byte count and serves zero-padded 512-bit
// blocks to the hasher until the hasher signals completion.
//
// Ports:
//   Clk, Rst_n     clock, asynchronous active-low reset
//   S_valid_I      input word valid
//   S_ready_O      input word ready (high only while filling)
//   S_data_I       message word, little-endian (byte 0 = bits [7:0])
//   S_keep_I       valid-byte thermometer on the last word
//   S_last_I       last word of the message
//   Addr_I         block index requested by the hasher
//   Msg_O          16 x 32-bit block at Addr_I, bytes past Byte_num_O zeroed
//   Byte_num_O     byte count of the issued message (0..1024)
//   Update_O       one-cycle start pulse for the hasher
//   Done_I         hasher result-valid level
//   Busy_O         message issued, hash not yet complete
//   Err_O          overflow flag for the current/last message
module chunk_loader (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              S_valid_I,
  output logic              S_ready_O,
  input  logic [31:0]       S_data_I,
  input  logic [3:0]        S_keep_I,
  input  logic              S_last_I,
  input  logic [9:0]        Addr_I,
  output logic [15:0][31:0] Msg_O,
  output logic [10:0]       Byte_num_O,
  output logic              Update_O,
  input  logic              Done_I,
  output logic              Busy_O,
  output logic              Err_O
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [15:0][15:0][31:0] mem_q;
  logic [8:0]              word_cnt_q;
  logic [10:0]             byte_cnt_q;
  logic                    first_q;
  logic                    done_q;
  logic                    err_q;

  logic                    accept;
  logic [8:0]              word_idx;
  logic [10:0]             byte_base;
  logic [2:0]              keep_cnt;
  logic [11:0]             byte_sum;
  logic [10:0]             byte_next;
  logic [31:0]             wr_data;
  logic                    err_next;

  assign Err_O = err_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Completion is a rising edge of Done_I seen in WAIT, so a level left high
  // from the previous message cannot release the next one early.
  always_comb begin
    state_d   = state_q;
    S_ready_O = 1'b0;
    Update_O  = 1'b0;
    Busy_O    = 1'b0;
    case (state_q)
      ST_FILL: begin
        S_ready_O = 1'b1;
        if (S_valid_I && S_last_I) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        Update_O = 1'b1;
        Busy_O   = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        Busy_O = 1'b1;
        if (Done_I && !done_q) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // first_q marks that the next accepted word starts a new message, so the
  // counters and error flag are treated as zero for that word.
  always_comb begin
    accept    = S_valid_I && S_ready_O;
    word_idx  = first_q ? 9'd0 : word_cnt_q;
    byte_base = first_q ? 11'd0 : byte_cnt_q;
    casez (S_keep_I)
      4'b???0: keep_cnt = 3'd0;
      4'b??01: keep_cnt = 3'd1;
      4'b?011: keep_cnt = 3'd2;
      4'b0111: keep_cnt = 3'd3;
      default: keep_cnt = 3'd4;
    endcase
    byte_sum  = {1'b0, byte_base} + (S_last_I ? {9'd0, keep_cnt} : 12'd4);
    byte_next = (byte_sum > 12'd1024) ? 11'd1024 : byte_sum[10:0];
    wr_data   = S_data_I;
    for (int b = 0; b < 4; b++) begin
      if (S_last_I && (3'(b) >= keep_cnt)) begin
        wr_data[8*b +: 8] = 8'h00;
      end
    end
    err_next = (first_q ? 1'b0 : err_q) | word_idx[8];
  end

  // Word index saturates at 256 so an overlong message can never wrap back
  // into block 0; everything past word 255 is dropped and flagged.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mem_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      Byte_num_O <= '0;
      first_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= Done_I;
      if (accept) begin
        first_q    <= 1'b0;
        err_q      <= err_next;
        byte_cnt_q <= byte_next;
        if (!word_idx[8]) begin
          mem_q[word_idx[7:4]][word_idx[3:0]] <= wr_data;
          word_cnt_q <= word_idx + 9'd1;
        end else begin
          word_cnt_q <= word_idx;
        end
        if (S_last_I) begin
          Byte_num_O <= byte_next;
        end
      end
      if ((state_q == ST_WAIT) && (state_d == ST_FILL)) begin
        first_q <= 1'b1;
      end
    end
  end

  // Bytes at or beyond the issued length read as zero, which pads partial
  // blocks and hides stale data from earlier messages without clearing.
  always_comb begin
    Msg_O = '0;
    if (Addr_I[9:4] == 6'd0) begin
      for (int i = 0; i < 16; i++) begin
        for (int b = 0; b < 4; b++) begin
          if ({1'b0, Addr_I[3:0], 4'(i), 2'(b)} < Byte_num_O) begin
            Msg_O[i][8*b +: 8] = mem_q[Addr_I[3:0]][i][8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_chunk_loader.sv
// tb_chunk_loader
// Directed self-checking bench for chunk_loader: full block, partial and
// empty messages, non-thermometer keep, full chunk, overflow, Done_I
// edge handshake and reset in the middle of a fill.
module tb_chunk_loader;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic              S_valid_I;
  logic              S_ready_O;
  logic [31:0]       S_data_I;
  logic [3:0]        S_keep_I;
  logic              S_last_I;
  logic [9:0]        Addr_I;
  logic [15:0][31:0] Msg_O;
  logic [10:0]       Byte_num_O;
  logic              Update_O;
  logic              Done_I;
  logic              Busy_O;
  logic              Err_O;

  int                total  = 0;
  int                passed = 0;
  int                failed = 0;
  logic [15:0][31:0] exp_blk;

  always #5 Clk = ~Clk;

  chunk_loader dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .S_valid_I  (S_valid_I),
    .S_ready_O  (S_ready_O),
    .S_data_I   (S_data_I),
    .S_keep_I   (S_keep_I),
    .S_last_I   (S_last_I),
    .Addr_I     (Addr_I),
    .Msg_O      (Msg_O),
    .Byte_num_O (Byte_num_O),
    .Update_O   (Update_O),
    .Done_I     (Done_I),
    .Busy_O     (Busy_O),
    .Err_O      (Err_O)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one word and holds it until it is accepted (bounded wait).
  task automatic applyStimulus(input logic [31:0] data, input logic [3:0] keep,
                               input logic last);
    int waited = 0;
    S_valid_I = 1'b1;
    S_data_I  = data;
    S_keep_I  = keep;
    S_last_I  = last;
    while (!S_ready_O && waited < 50) begin
      @(posedge Clk);
      #1;
      waited++;
    end
    if (!S_ready_O) begin
      checkOutput("handshake_timeout", 32'(S_ready_O), 32'd1);
    end
    @(posedge Clk);
    #1;
    S_valid_I = 1'b0;
    S_last_I  = 1'b0;
  endtask

  // Called one step after the last word's handshake edge: expects the ISSUE
  // cycle now and a single-cycle pulse.
  task automatic checkIssue(input string tag, input int bytes, input logic err);
    checkOutput({tag, "_update"}, 32'(Update_O), 32'd1);
    checkOutput({tag, "_byte_num"}, 32'(Byte_num_O), 32'(bytes));
    checkOutput({tag, "_err"}, 32'(Err_O), 32'(err));
    checkOutput({tag, "_ready_issue"}, 32'(S_ready_O), 32'd0);
    checkOutput({tag, "_busy_issue"}, 32'(Busy_O), 32'd1);
    @(posedge Clk);
    #1;
    checkOutput({tag, "_update_off"}, 32'(Update_O), 32'd0);
    checkOutput({tag, "_busy_wait"}, 32'(Busy_O), 32'd1);
  endtask

  task automatic checkBlock(input string tag, input logic [9:0] addr,
                            input logic [15:0][31:0] expected);
    Addr_I = addr;
    #1;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("%s_w%0d", tag, i), Msg_O[i], expected[i]);
    end
  endtask

  task automatic pulseDone();
    @(negedge Clk);
    Done_I = 1'b1;
    @(posedge Clk);
    #1;
    Done_I = 1'b0;
    checkOutput("ready_after_done", 32'(S_ready_O), 32'd1);
    checkOutput("busy_after_done", 32'(Busy_O), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    S_valid_I = 1'b0;
    S_data_I  = '0;
    S_keep_I  = '0;
    S_last_I  = 1'b0;
    Addr_I    = '0;
    Done_I    = 1'b0;
    Rst_n     = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rst_ready", 32'(S_ready_O), 32'd1);
    checkOutput("rst_update", 32'(Update_O), 32'd0);
    checkOutput("rst_byte_num", 32'(Byte_num_O), 32'd0);
    checkOutput("rst_busy", 32'(Busy_O), 32'd0);
    checkOutput("rst_err", 32'(Err_O), 32'd0);
    checkOutput("rst_msg0", Msg_O[0], 32'd0);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    $display("[TB] full block");
    for (int j = 0; j < 16; j++) begin
      applyStimulus({8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)}, 4'hF, j == 15);
    end
    checkIssue("full_block", 64, 1'b0);
    for (int j = 0; j < 16; j++) begin
      exp_blk[j] = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
    end
    checkBlock("full_blk0", 10'd0, exp_blk);
    exp_blk = '0;
    checkBlock("full_blk1", 10'd1, exp_blk);
    pulseDone();

    $display("[TB] partial and empty messages");
    applyStimulus(32'hAABBCCDD, 4'h0, 1'b0);
    applyStimulus(32'h11223344, 4'h1, 1'b1);
    checkIssue("partial", 5, 1'b0);
    exp_blk    = '0;
    exp_blk[0] = 32'hAABBCCDD;
    exp_blk[1] = 32'h00000044;
    checkBlock("partial_blk0", 10'd0, exp_blk);
    pulseDone();

    applyStimulus(32'hDEADBEEF, 4'h0, 1'b1);
    checkIssue("empty", 0, 1'b0);
    exp_blk = '0;
    checkBlock("empty_blk0", 10'd0, exp_blk);
    pulseDone();

    applyStimulus(32'h44332211, 4'b1101, 1'b1);
    checkIssue("keep_1101", 1, 1'b0);
    exp_blk    = '0;
    exp_blk[0] = 32'h00000011;
    checkBlock("keep_1101_blk0", 10'd0, exp_blk);
    pulseDone();

    $display("[TB] full chunk");
    for (int j = 0; j < 256; j++) begin
      applyStimulus(32'hA5000000 + 32'(j), 4'hF, j == 255);
    end
    checkIssue("full_chunk", 1024, 1'b0);
    for (int i = 0; i < 16; i++) begin
      exp_blk[i] = 32'hA5000000 + 32'(240 + i);
    end
    checkBlock("chunk_blk15", 10'd15, exp_blk);
    exp_blk = '0;
    checkBlock("chunk_blk16", 10'd16, exp_blk);
    pulseDone();

    $display("[TB] overflow");
    for (int j = 0; j < 260; j++) begin
      applyStimulus(32'h5A000000 + 32'(j), 4'hF, j == 259);
    end
    checkIssue("overflow", 1024, 1'b1);
    for (int i = 0; i < 16; i++) begin
      exp_blk[i] = 32'h5A000000 + 32'(240 + i);
    end
    checkBlock("ovf_blk15", 10'd15, exp_blk);
    for (int i = 0; i < 16; i++) begin
      exp_blk[i] = 32'h5A000000 + 32'(i);
    end
    checkBlock("ovf_blk0", 10'd0, exp_blk);
    pulseDone();
    checkOutput("err_held_in_fill", 32'(Err_O), 32'd1);

    $display("[TB] done handshake");
    applyStimulus(32'h01020304, 4'hF, 1'b0);
    checkOutput("err_cleared", 32'(Err_O), 32'd0);
    Done_I = 1'b1;
    applyStimulus(32'h05060708, 4'hF, 1'b1);
    checkOutput("stale_byte_num", 32'(Byte_num_O), 32'd8);
    checkOutput("stale_update", 32'(Update_O), 32'd1);
    checkOutput("stale_ready_issue", 32'(S_ready_O), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk);
      #1;
      checkOutput($sformatf("stale_ready_wait%0d", c), 32'(S_ready_O), 32'd0);
    end
    Done_I = 1'b0;
    @(posedge Clk);
    #1;
    checkOutput("done_low_ready", 32'(S_ready_O), 32'd0);
    Done_I = 1'b1;
    @(posedge Clk);
    #1;
    Done_I = 1'b0;
    checkOutput("done_rise_ready", 32'(S_ready_O), 32'd1);
    checkOutput("done_rise_busy", 32'(Busy_O), 32'd0);

    $display("[TB] reset mid-fill");
    for (int j = 0; j < 10; j++) begin
      applyStimulus(32'hC0000000 + 32'(j), 4'hF, 1'b0);
    end
    Addr_I = 10'd0;
    Rst_n  = 1'b0;
    #1;
    checkOutput("midrst_ready", 32'(S_ready_O), 32'd1);
    checkOutput("midrst_update", 32'(Update_O), 32'd0);
    checkOutput("midrst_byte_num", 32'(Byte_num_O), 32'd0);
    checkOutput("midrst_busy", 32'(Busy_O), 32'd0);
    checkOutput("midrst_err", 32'(Err_O), 32'd0);
    checkOutput("midrst_msg0", Msg_O[0], 32'd0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    applyStimulus(32'h11111111, 4'hF, 1'b0);
    applyStimulus(32'h22222222, 4'hF, 1'b0);
    applyStimulus(32'h33333333, 4'hF, 1'b1);
    checkIssue("post_reset", 12, 1'b0);
    exp_blk    = '0;
    exp_blk[0] = 32'h11111111;
    exp_blk[1] = 32'h22222222;
    exp_blk[2] = 32'h33333333;
    checkBlock("post_reset_blk0", 10'd0, exp_blk);
    pulseDone();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
